// File: rtl/vc_fifo.sv
`timescale 1ns/1ps
// vc_fifo
// NumVC independent circular flit queues (virtual channels) sharing one storage
// array addressed {vc, ptr}. Each VC has its own read/write pointer and
// occupancy counter. Status flags are decoded from those counters. Rejected
// writes and reads set sticky error flags.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   wr_en/wr_vc/buf_in write request, target VC, write data
//   rd_en/rd_vc        read request, source VC
//   buf_out/out_vc     registered read data and the VC it came from
//   out_valid          one-cycle pulse when buf_out was loaded by a read
//   buf_empty/full     per-VC count==0 / count==FifoSize
//   almost_full        per-VC count>=AlmostFullThresh (upstream stop signal)
//   fifo_counter       packed per-VC occupancy, VC v at [v*(lg+1) +: lg+1]
//   overflow/underflow sticky rejected-write / rejected-read flags
module vc_fifo #(
  parameter int unsigned DataWidth        = 85,
  parameter int unsigned NumVC            = 4,
  parameter int unsigned VcIdxWidth       = 2,
  parameter int unsigned fifo_lg_size     = 4,
  parameter int unsigned AlmostFullThresh = 12
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_en,
  input  logic [VcIdxWidth-1:0]                 wr_vc,
  input  logic [DataWidth-1:0]                  buf_in,
  input  logic                                  rd_en,
  input  logic [VcIdxWidth-1:0]                 rd_vc,
  output logic [DataWidth-1:0]                  buf_out,
  output logic                                  out_valid,
  output logic [VcIdxWidth-1:0]                 out_vc,
  output logic [NumVC-1:0]                      buf_empty,
  output logic [NumVC-1:0]                      buf_full,
  output logic [NumVC-1:0]                      almost_full,
  output logic [NumVC*(fifo_lg_size+1)-1:0]     fifo_counter,
  output logic                                  overflow,
  output logic                                  underflow
);

  localparam int unsigned FifoSize  = 1 << fifo_lg_size;
  localparam int unsigned CntWidth  = fifo_lg_size + 1;
  localparam int unsigned AddrWidth = VcIdxWidth + fifo_lg_size;
  localparam int unsigned Depth     = NumVC * FifoSize;

  localparam logic [CntWidth-1:0] FullCnt  = CntWidth'(FifoSize);
  localparam logic [CntWidth-1:0] AfullCnt = CntWidth'(AlmostFullThresh);

  // Shared storage; deliberately not reset, every VC reads as empty after rst.
  logic [DataWidth-1:0]    r_mem [Depth];

  logic [fifo_lg_size-1:0] r_wr_ptr [NumVC];
  logic [fifo_lg_size-1:0] r_rd_ptr [NumVC];
  logic [CntWidth-1:0]     r_count  [NumVC];

  logic [DataWidth-1:0]    r_buf_out;
  logic                    r_out_valid;
  logic [VcIdxWidth-1:0]   r_out_vc;
  logic                    r_overflow;
  logic                    r_underflow;

  logic [NumVC-1:0]        w_empty;
  logic [NumVC-1:0]        w_full;
  logic [NumVC-1:0]        w_afull;
  logic [NumVC*CntWidth-1:0] w_counter;
  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic [NumVC-1:0]        w_wr_hit;
  logic [NumVC-1:0]        w_rd_hit;
  logic [AddrWidth-1:0]    w_wr_addr;
  logic [AddrWidth-1:0]    w_rd_addr;

  // Status decode from the registered counters only, so a same-cycle read
  // never makes room for a write and a same-cycle write never falls through.
  always_comb begin
    w_empty   = '0;
    w_full    = '0;
    w_afull   = '0;
    w_counter = '0;
    for (int v = 0; v < NumVC; v++) begin
      w_empty[v]                       = (r_count[v] == '0);
      w_full[v]                        = (r_count[v] == FullCnt);
      w_afull[v]                       = (r_count[v] >= AfullCnt);
      w_counter[v*CntWidth +: CntWidth] = r_count[v];
    end
  end

  always_comb begin
    w_wr_acc  = wr_en && !w_full[wr_vc];
    w_rd_acc  = rd_en && !w_empty[rd_vc];
    w_wr_addr = {wr_vc, r_wr_ptr[wr_vc]};
    w_rd_addr = {rd_vc, r_rd_ptr[rd_vc]};
    w_wr_hit  = '0;
    w_rd_hit  = '0;
    for (int v = 0; v < NumVC; v++) begin
      w_wr_hit[v] = w_wr_acc && (wr_vc == VcIdxWidth'(v));
      w_rd_hit[v] = w_rd_acc && (rd_vc == VcIdxWidth'(v));
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_addr] <= buf_in;
    end
  end

  // Per-VC pointers and occupancy; pointers wrap naturally at FifoSize.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NumVC; v++) begin
        r_wr_ptr[v] <= '0;
        r_rd_ptr[v] <= '0;
        r_count[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < NumVC; v++) begin
        if (w_wr_hit[v]) begin
          r_wr_ptr[v] <= r_wr_ptr[v] + fifo_lg_size'(1);
        end
        if (w_rd_hit[v]) begin
          r_rd_ptr[v] <= r_rd_ptr[v] + fifo_lg_size'(1);
        end
        case ({w_wr_hit[v], w_rd_hit[v]})
          2'b10:   r_count[v] <= r_count[v] + CntWidth'(1);
          2'b01:   r_count[v] <= r_count[v] - CntWidth'(1);
          default: r_count[v] <= r_count[v];
        endcase
      end
    end
  end

  // Read port: buf_out/out_vc hold unless a read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_out   <= '0;
      r_out_vc    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_buf_out <= r_mem[w_rd_addr];
        r_out_vc  <= rd_vc;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && !w_wr_acc) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && !w_rd_acc) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign buf_out      = r_buf_out;
  assign out_valid    = r_out_valid;
  assign out_vc       = r_out_vc;
  assign buf_empty    = w_empty;
  assign buf_full     = w_full;
  assign almost_full  = w_afull;
  assign fifo_counter = w_counter;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_vc_fifo.sv
`timescale 1ns/1ps
// Scoreboard bench for vc_fifo: a queue-per-VC reference model decides which
// requests are accepted; accepted reads push their expected flit into exp_q,
// and an independent monitor pops and compares whenever out_valid is seen.
module tb_vc_fifo;

  localparam int DW = 85;
  localparam int NV = 4;
  localparam int VW = 2;
  localparam int LG = 4;
  localparam int SZ = 16;
  localparam int AF = 12;
  localparam int CW = LG + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [VW-1:0]   wr_vc = '0;
  logic [DW-1:0]   buf_in = '0;
  logic            rd_en = 1'b0;
  logic [VW-1:0]   rd_vc = '0;
  logic [DW-1:0]   buf_out;
  logic            out_valid;
  logic [VW-1:0]   out_vc;
  logic [NV-1:0]   buf_empty;
  logic [NV-1:0]   buf_full;
  logic [NV-1:0]   almost_full;
  logic [NV*CW-1:0] fifo_counter;
  logic            overflow;
  logic            underflow;

  vc_fifo #(
    .DataWidth(DW), .NumVC(NV), .VcIdxWidth(VW), .fifo_lg_size(LG), .AlmostFullThresh(AF)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_vc(wr_vc), .buf_in(buf_in),
    .rd_en(rd_en), .rd_vc(rd_vc), .buf_out(buf_out), .out_valid(out_valid),
    .out_vc(out_vc), .buf_empty(buf_empty), .buf_full(buf_full),
    .almost_full(almost_full), .fifo_counter(fifo_counter),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  logic [DW-1:0]    mq [NV][$];
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;
  logic [VW+DW-1:0] exp_q [$];
  logic [DW-1:0]    last_data = '0;
  logic [VW-1:0]    last_vc = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_status();
    logic [NV-1:0]    e_empty, e_full, e_af;
    logic [NV*CW-1:0] e_cnt;
    for (int v = 0; v < NV; v++) begin
      e_empty[v]         = (mq[v].size() == 0);
      e_full[v]          = (mq[v].size() == SZ);
      e_af[v]            = (mq[v].size() >= AF);
      e_cnt[v*CW +: CW]  = CW'(mq[v].size());
    end
    chk("buf_empty", 128'(buf_empty), 128'(e_empty));
    chk("buf_full", 128'(buf_full), 128'(e_full));
    chk("almost_full", 128'(almost_full), 128'(e_af));
    chk("fifo_counter", 128'(fifo_counter), 128'(e_cnt));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("underflow", 128'(underflow), 128'(m_unf));
  endtask

  // One clock of stimulus: drive at negedge, update model, check after posedge.
  task automatic step(input logic we, input logic [VW-1:0] wv, input logic [DW-1:0] wd,
                      input logic re, input logic [VW-1:0] rv);
    bit wacc, racc;
    @(negedge clk);
    wr_en  = we;
    wr_vc  = wv;
    buf_in = wd;
    rd_en  = re;
    rd_vc  = rv;
    wacc = we && (mq[wv].size() < SZ);
    racc = re && (mq[rv].size() != 0);
    if (we && !wacc) m_ovf = 1'b1;
    if (re && !racc) m_unf = 1'b1;
    if (racc) exp_q.push_back({rv, mq[rv].pop_front()});
    if (wacc) mq[wv].push_back(wd);
    @(posedge clk);
    #1;
    chk("out_valid", 128'(out_valid), 128'(racc));
    check_status();
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom, $urandom, $urandom});
  endfunction

  // Monitor: pops the scoreboard on every out_valid, checks hold otherwise.
  always @(negedge clk or posedge rst) begin
    logic [VW+DW-1:0] e;
    if (rst) begin
      last_data = '0;
      last_vc   = '0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rd_unexpected: got out_valid=1 vc=%0d data=%0h expected no read", out_vc,
                 buf_out);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", 128'(buf_out), 128'(e[DW-1:0]));
        chk("rd_vc", 128'(out_vc), 128'(e[VW+DW-1:DW]));
        last_data = e[DW-1:0];
        last_vc   = e[VW+DW-1:DW];
      end
    end else begin
      chk("hold_data", 128'(buf_out), 128'(last_data));
      chk("hold_vc", 128'(out_vc), 128'(last_vc));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle();
    chk("reset_buf_out", 128'(buf_out), 128'(0));

    // In-order readback on VC2
    for (int i = 1; i <= 3; i++) step(1'b1, 2'd2, DW'(i), 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 2'd2);

    // Fill VC1, then overflow with simultaneous read
    for (int i = 0; i < SZ; i++) step(1'b1, 2'd1, DW'(16'h100 + i), 1'b0, '0);
    step(1'b1, 2'd1, DW'(16'hBAD), 1'b1, 2'd1);

    // Read empty VC0 while writing it: rejected, then next read returns 0xA
    step(1'b1, 2'd0, DW'(4'hA), 1'b1, 2'd0);
    step(1'b0, '0, '0, 1'b1, 2'd0);

    // Independent VCs in one cycle, then pointer wrap on VC3
    step(1'b1, 2'd3, DW'(16'h300), 1'b1, 2'd1);
    for (int i = 1; i <= 40; i++) step(1'b1, 2'd3, DW'(16'h300 + i), 1'b1, 2'd3);
    step(1'b0, '0, '0, 1'b1, 2'd3);

    // Randomized traffic: write-heavy then read-heavy phases
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 150; i++) begin
        logic we, re;
        we = ($urandom_range(99) < ((p % 2 == 0) ? 75 : 30));
        re = ($urandom_range(99) < ((p % 2 == 0) ? 30 : 75));
        step(we, VW'($urandom_range(NV - 1)), rnd_data(), re, VW'($urandom_range(NV - 1)));
      end
    end

    // Drain, then queue 5 flits in VC0 for the reset test
    for (int v = 0; v < NV; v++) begin
      for (int i = 0; i < SZ; i++) step(1'b0, '0, '0, 1'b1, VW'(v));
    end
    for (int i = 0; i < 5; i++) step(1'b1, 2'd0, rnd_data(), 1'b0, '0);
    idle();
    idle();
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    // Asynchronous reset mid-cycle: outputs clear without a clock edge
    #2;
    rst = 1'b1;
    #1;
    for (int v = 0; v < NV; v++) mq[v].delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_status();
    chk("rst_buf_out", 128'(buf_out), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_vc", 128'(out_vc), 128'(0));
    // Read requested while reset is held must not pulse out_valid
    @(negedge clk);
    rd_en = 1'b1;
    rd_vc = 2'd0;
    @(posedge clk);
    #1;
    chk("rst_read_valid", 128'(out_valid), 128'(0));
    @(negedge clk);
    rd_en = 1'b0;
    rst   = 1'b0;
    step(1'b0, '0, '0, 1'b1, 2'd0);
    idle();
    chk("final_drained", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vc_fifo.md
# vc_fifo

Parametrised multi-channel successor to the router's single flit FIFO. It holds `NumVC` independent circular queues (virtual channels) in one shared storage array. Each queue has its own pointers, occupancy counter and status flags, plus an almost-full threshold for upstream back-pressure. The block sits between the router input port and the reduction/forwarding logic and carries 85-bit children-tagged flits by default. It adds sticky error flags for rejected writes and reads.

## Interface
Parameters:
- `DataWidth`, 85, flit width incl. children field (FlitWidth+ChildrenWidth)
- `NumVC`, 4, number of virtual-channel queues (power of two, ≥2)
- `VcIdxWidth`, 2, log2(NumVC)
- `fifo_lg_size`, 4, log2 of per-VC depth; `FifoSize` = 1<<fifo_lg_size
- `AlmostFullThresh`, 12, per-VC occupancy at or above which `almost_full[v]` asserts (1..FifoSize)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `wr_en`  in  1  write request
- `wr_vc`  in  VcIdxWidth  target VC of write
- `buf_in`  in  DataWidth  write data
- `rd_en`  in  1  read request
- `rd_vc`  in  VcIdxWidth  source VC of read
- `buf_out`  out  DataWidth  registered read data
- `out_valid`  out  1  one-cycle pulse: `buf_out` updated by an accepted read
- `out_vc`  out  VcIdxWidth  VC of the data in `buf_out`
- `buf_empty`  out  NumVC  per-VC count==0
- `buf_full`  out  NumVC  per-VC count==FifoSize
- `almost_full`  out  NumVC  per-VC count≥AlmostFullThresh
- `fifo_counter`  out  NumVC*(fifo_lg_size+1)  packed per-VC occupancy; VC v at bits [v*(fifo_lg_size+1) +: fifo_lg_size+1]
- `overflow`  out  1  sticky: a write was rejected because the VC was full
- `underflow`  out  1  sticky: a read was rejected because the VC was empty

## Operation
- Storage: NumVC*FifoSize entries addressed {vc, ptr}. Per-VC `wr_ptr`/`rd_ptr` are fifo_lg_size bits and wrap modulo FifoSize. Counters are fifo_lg_size+1 bits.
- Write accepted iff `wr_en && !buf_full[wr_vc]`. The entry is stored at {wr_vc, wr_ptr}, and that VC's `wr_ptr` increments. Every accepted write counts; there is no payload-based filtering.
- Read accepted iff `rd_en && !buf_empty[rd_vc]`. `buf_out` is loaded from {rd_vc, rd_ptr}, `out_vc` is loaded with `rd_vc`, `out_valid` is 1 for one cycle, and that VC's `rd_ptr` increments.
- No accepted read: `buf_out` and `out_vc` hold their values, and `out_valid` is 0.
- Counter update per VC v: +1 if write accepted to v only; −1 if read accepted from v only; unchanged if both or neither.
- Full/empty checks use the registered count before the edge:
  - Write to a full VC with a simultaneous read of the same VC: the write is rejected and `overflow` sets.
  - Read of an empty VC with a simultaneous write to it: the read is rejected, `underflow` sets, and there is no fall-through.
- Operations on different VCs in the same cycle are fully independent.
- `overflow`/`underflow` are cleared only by `rst`.
- Status flags are combinational decodes of the registered counters.
- Reset (async, `rst`=1): all pointers, counters, `buf_out`, `out_vc`, `out_valid`, `overflow` and `underflow` go to 0. Storage contents are not cleared; they are unobservable because every VC is empty. After reset `buf_empty` is all ones, and `buf_full` and `almost_full` are all zeros.
- Reset asserted mid-operation discards all queued flits. A read in the reset cycle does not produce `out_valid`.

## Timing
- Write-to-readable latency: 1 cycle. Data written at edge N can be read by a request sampled at edge N+1.
- Read latency: 1 cycle. A request sampled at edge N gives `buf_out`/`out_valid` valid after edge N.
- Flags and counters reflect edge-N operations immediately after edge N.
- Back-to-back reads of one VC sustain one flit per cycle. Wrap-around of `rd_ptr`/`wr_ptr` from FifoSize−1 to 0 introduces no bubble.
- Upstream must treat `almost_full` as its stop signal. This leaves FifoSize−AlmostFullThresh cycles of slack.

## Test plan
- Reset, then idle → `buf_empty`=4'b1111, `fifo_counter`=0, `buf_out`=0, `out_valid`=0, `overflow`=`underflow`=0.
- Write 0x1..0x3 to VC2 on consecutive cycles, then read VC2 three times → `buf_out` = 0x1, 0x2, 0x3 with `out_vc`=2 and `out_valid` high on three cycles. Counter for VC2 reads 3, then 0.
- Fill VC1 with 16 writes → `almost_full[1]` rises after the 12th write and `buf_full[1]` after the 16th. A 17th write with a simultaneous VC1 read → read returns the first flit, count stays 16→15, `overflow`=1.
- Read empty VC0 while writing 0xA to VC0 → `underflow`=1, `out_valid`=0, VC0 count=1. The next cycle's read returns 0xA.
- Interleave a write to VC3 with a read from VC1 in the same cycle, and run 40 write/read pairs on VC3 to force pointer wrap → FIFO order is preserved, VC1 is unaffected, and VC3 count never exceeds 1.
- Assert `rst` asynchronously (mid-cycle) with 5 flits queued in VC0 → all outputs and counters are 0 immediately. A post-reset read of VC0 gives `underflow`=1 and no data.
